// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the decode-side
// instruction handshake and control (redirect/skip/halt) returning from decode/execute.
interface fetch_if #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned INSTR_WIDTH = 10
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   instr_valid;
  logic                   decode_ready;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   skip;
  logic                   halt;
  logic                   halted;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
    input  imem_rdata, imem_ready, decode_ready, redirect_valid, redirect_pc, skip, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
    output imem_rdata, imem_ready, decode_ready, redirect_valid, redirect_pc, skip, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, issues single-outstanding memory requests and
// hands each fetched instruction to decode through a valid/ready instruction register.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 10,
  parameter int unsigned         INSTR_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StHalted} state_e;

  localparam logic [PC_WIDTH-1:0] PcOne = 1;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic                   pending_q, pending_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      pending_q  <= pending_d;
    end
  end

  // addr_q is reloaded only when a new request starts, so an in-flight address
  // stays stable even after a redirect has already moved pc.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    pending_d  = pending_q;
    unique case (state_q)
      StIdle: begin
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        addr_d  = pc_d;
        state_d = StFetch;
      end
      StFetch: begin
        if (bus.imem_ready) begin
          if (pending_q || bus.redirect_valid) begin
            // Stale response: drop it and re-issue at the redirected pc.
            if (bus.redirect_valid) pc_d = bus.redirect_pc;
            pending_d = 1'b0;
            addr_d    = pc_d;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + PcOne;
            valid_d    = 1'b1;
            state_d    = StHold;
          end
        end else if (bus.redirect_valid) begin
          pc_d      = bus.redirect_pc;
          pending_d = 1'b1;
        end
      end
      StHold: begin
        if (bus.decode_ready) begin
          valid_d = 1'b0;
          if (bus.halt) begin
            halted_d = 1'b1;
            state_d  = StHalted;
          end else begin
            if (bus.redirect_valid) pc_d = bus.redirect_pc;
            else if (bus.skip)      pc_d = pc_q + PcOne;
            addr_d  = pc_d;
            state_d = StFetch;
          end
        end
      end
      StHalted: begin
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.imem_req    = (state_q == StFetch);
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a zero/fixed-wait memory model feeds two instances,
// one at RESET_PC=0 and one at RESET_PC=0x3FE for the wrap cases.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  fetch_if #(.PC_WIDTH(10), .INSTR_WIDTH(10)) bus ();
  fetch_if #(.PC_WIDTH(10), .INSTR_WIDTH(10)) bus2 ();

  fetch_unit #(.PC_WIDTH(10), .INSTR_WIDTH(10), .RESET_PC(10'h000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fetch_unit #(.PC_WIDTH(10), .INSTR_WIDTH(10), .RESET_PC(10'h3FE)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  logic [9:0] mem [1024];
  int   lat;
  int   wcnt;
  logic auto_en, man_ready;
  int   checks = 0;
  int   failures = 0;

  assign bus.imem_rdata  = mem[bus.imem_addr];
  assign bus.imem_ready  = man_ready | (auto_en & bus.imem_req & (wcnt == lat));
  assign bus2.imem_rdata = mem[bus2.imem_addr];
  assign bus2.imem_ready = bus2.imem_req;

  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.decode_ready   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 10'h0;
    bus.skip           = 1'b0;
    bus.halt           = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    bus.decode_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h55;
    auto_en = 1'b1; man_ready = 1'b0; lat = 0;
    tick(); tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.halted, bus.instr, bus.instr_pc}
        !== {1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 10'h000}) begin
      failures++;
      $display("FAIL reset_values got req=%b addr=%h v=%b h=%b instr=%h pc=%h exp all zero",
               bus.imem_req, bus.imem_addr, bus.instr_valid, bus.halted, bus.instr, bus.instr_pc);
    end
    checks++;
    if ({bus2.imem_req, bus2.imem_addr} !== {1'b0, 10'h3FE}) begin
      failures++;
      $display("FAIL reset_pc2 got req=%b addr=%h exp req=0 addr=3fe",
               bus2.imem_req, bus2.imem_addr);
    end
    clear_inputs();
  endtask

  task automatic test_sequential();
    logic [9:0] exp [4];
    exp = '{10'h101, 10'h202, 10'h303, 10'h004};
    mem[0] = 10'h101; mem[1] = 10'h202; mem[2] = 10'h303; mem[3] = 10'h004;
    lat = 0;
    do_reset();
    bus.decode_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 10'(i), 1'b0}) begin
        failures++;
        $display("FAIL seq_req[%0d] got req=%b addr=%h v=%b exp req=1 addr=%h v=0", i,
                 bus.imem_req, bus.imem_addr, bus.instr_valid, 10'(i));
      end
      tick();
      checks++;
      if ({bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc}
          !== {1'b1, 1'b0, exp[i], 10'(i)}) begin
        failures++;
        $display("FAIL seq_instr[%0d] got v=%b req=%b instr=%h pc=%h exp v=1 req=0 instr=%h pc=%h",
                 i, bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc, exp[i], 10'(i));
      end
    end
    clear_inputs();
  endtask

  task automatic test_wait_backpressure();
    mem[0] = 10'h155; mem[1] = 10'h2AA;
    lat = 3;
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 10'h000, 1'b0}) begin
        failures++;
        $display("FAIL wait_addr[%0d] got req=%b addr=%h v=%b exp req=1 addr=000 v=0", i,
                 bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc}
          !== {1'b1, 1'b0, 10'h155, 10'h000}) begin
        failures++;
        $display("FAIL stall_hold[%0d] got v=%b req=%b instr=%h pc=%h exp v=1 req=0 instr=155 pc=000",
                 i, bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc);
      end
    end
    bus.decode_ready = 1'b1;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 10'h001, 1'b0}) begin
      failures++;
      $display("FAIL stall_next got req=%b addr=%h v=%b exp req=1 addr=001 v=0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    clear_inputs();
  endtask

  task automatic test_redirect_skip_halt();
    mem[5] = 10'h055; mem[10'h2A] = 10'h12A; mem[7] = 10'h077; mem[9] = 10'h099;
    lat = 0;
    do_reset();
    rst = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h005;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 10'h005}) begin
      failures++;
      $display("FAIL idle_redirect got req=%b addr=%h exp req=1 addr=005",
               bus.imem_req, bus.imem_addr);
    end
    bus.redirect_valid = 1'b0;
    tick();
    checks++;
    if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 10'h055, 10'h005}) begin
      failures++;
      $display("FAIL hold_pc5 got v=%b instr=%h pc=%h exp v=1 instr=055 pc=005",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    // Redirect without decode_ready must not act.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h02A;
    tick();
    checks++;
    if ({bus.instr_valid, bus.imem_req, bus.instr_pc} !== {1'b1, 1'b0, 10'h005}) begin
      failures++;
      $display("FAIL redirect_no_consume got v=%b req=%b pc=%h exp v=1 req=0 pc=005",
               bus.instr_valid, bus.imem_req, bus.instr_pc);
    end
    bus.decode_ready = 1'b1;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 10'h02A, 1'b0}) begin
      failures++;
      $display("FAIL consume_redirect got req=%b addr=%h v=%b exp req=1 addr=02a v=0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    clear_inputs();
    tick();
    checks++;
    if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 10'h12A, 10'h02A}) begin
      failures++;
      $display("FAIL hold_pc2a got v=%b instr=%h pc=%h exp v=1 instr=12a pc=02a",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    bus.decode_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h007;
    tick();
    clear_inputs();
    tick();
    checks++;
    if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 10'h077, 10'h007}) begin
      failures++;
      $display("FAIL hold_pc7 got v=%b instr=%h pc=%h exp v=1 instr=077 pc=007",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    bus.decode_ready = 1'b1; bus.skip = 1'b1;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 10'h009}) begin
      failures++;
      $display("FAIL skip_addr got req=%b addr=%h exp req=1 addr=009",
               bus.imem_req, bus.imem_addr);
    end
    clear_inputs();
    tick();
    bus.decode_ready = 1'b1; bus.halt = 1'b1; bus.skip = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h033;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.halted, bus.imem_req, bus.instr_valid} !== {1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL halted[%0d] got h=%b req=%b v=%b exp h=1 req=0 v=0", i,
                 bus.halted, bus.imem_req, bus.instr_valid);
      end
      bus.halt = ~bus.halt;
    end
    clear_inputs();
  endtask

  task automatic test_inflight_redirect();
    mem[4] = 10'h3C4; mem[10'h10] = 10'h210;
    lat = 2;
    do_reset();
    rst = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h004;
    tick();
    bus.redirect_pc = 10'h010;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 10'h004, 1'b0}) begin
        failures++;
        $display("FAIL inflight_hold[%0d] got req=%b addr=%h v=%b exp req=1 addr=004 v=0", i,
                 bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      tick();
      bus.redirect_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 10'h010, 1'b0}) begin
        failures++;
        $display("FAIL inflight_next[%0d] got req=%b addr=%h v=%b exp req=1 addr=010 v=0", i,
                 bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
      tick();
    end
    checks++;
    if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 10'h210, 10'h010}) begin
      failures++;
      $display("FAIL inflight_instr got v=%b instr=%h pc=%h exp v=1 instr=210 pc=010",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    logic [9:0] exp_addr [3];
    exp_addr = '{10'h3FE, 10'h3FF, 10'h000};
    mem[10'h3FE] = 10'h1FE; mem[10'h3FF] = 10'h1FF;
    for (int run = 0; run < 2; run++) begin
      rst2 = 1'b1;
      tick(); tick();
      rst2 = 1'b0;
      bus2.decode_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        bus2.skip = (run == 1 && i == 2);
        tick();
        checks++;
        if ({bus2.imem_req, bus2.imem_addr}
            !== {1'b1, (run == 1 && i == 2) ? 10'h001 : exp_addr[i]}) begin
          failures++;
          $display("FAIL wrap_addr[%0d.%0d] got req=%b addr=%h exp req=1 addr=%h", run, i,
                   bus2.imem_req, bus2.imem_addr, (run == 1 && i == 2) ? 10'h001 : exp_addr[i]);
        end
        bus2.skip = 1'b0;
        if (i < 2) begin
          tick();
          checks++;
          if ({bus2.instr_valid, bus2.instr_pc} !== {1'b1, exp_addr[i]}) begin
            failures++;
            $display("FAIL wrap_pc[%0d.%0d] got v=%b pc=%h exp v=1 pc=%h", run, i,
                     bus2.instr_valid, bus2.instr_pc, exp_addr[i]);
          end
        end
      end
    end
    bus2.decode_ready = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    mem[0] = 10'h0AB; mem[6] = 10'h3E6;
    auto_en = 1'b0; man_ready = 1'b0;
    do_reset();
    rst = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h006;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 10'h006}) begin
      failures++;
      $display("FAIL midfetch_wait got req=%b addr=%h exp req=1 addr=006",
               bus.imem_req, bus.imem_addr);
    end
    rst = 1'b1; man_ready = 1'b1;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.halted, bus.instr, bus.instr_pc}
        !== {1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 10'h000}) begin
      failures++;
      $display("FAIL midfetch_reset got req=%b addr=%h v=%b h=%b instr=%h pc=%h exp all zero",
               bus.imem_req, bus.imem_addr, bus.instr_valid, bus.halted, bus.instr, bus.instr_pc);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 10'h000, 1'b0}) begin
      failures++;
      $display("FAIL midfetch_late_ready got req=%b addr=%h v=%b exp req=1 addr=000 v=0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    man_ready = 1'b0; auto_en = 1'b1; lat = 0;
    tick();
    checks++;
    if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 10'h0AB, 10'h000}) begin
      failures++;
      $display("FAIL midfetch_restart got v=%b instr=%h pc=%h exp v=1 instr=0ab pc=000",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 10'(i) ^ 10'h2A5;
    bus2.decode_ready = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 10'h0;
    bus2.skip = 1'b0; bus2.halt = 1'b0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_wait_backpressure();
    test_redirect_skip_halt();
    test_inflight_redirect();
    test_wrap();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
